// File: rtl/control_pkg.sv
`default_nettype none
// ============================================================================
// Module   : control_pkg
// Purpose  : Shared types and helpers for the multi-port packet framing
//            control FSM: port state encoding, error cause encoding and the
//            beat counter width function.
// Revision : 1.0 - initial multi-port release
// ============================================================================
package control_pkg;

  // Per-port framing state
  typedef enum logic [1:0] {
    ST_RESET    = 2'd0,
    ST_IDLE     = 2'd1,
    ST_WAIT_EOP = 2'd2,
    ST_ERROR    = 2'd3
  } state_t;

  // Last error cause reported on err_code
  typedef enum logic [1:0] {
    ERR_NONE       = 2'd0,
    ERR_EOP_NO_SOP = 2'd1,
    ERR_SOP_IN_PKT = 2'd2,
    ERR_TOO_LONG   = 2'd3
  } err_code_t;

  // Width needed to hold 0..max_beats, never narrower than one bit
  function automatic int beat_cnt_width(input int max_beats);
    int w;
    w = $clog2(max_beats + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/control_port_fsm.sv
`default_nettype none
// ============================================================================
// Module   : control_port_fsm
// Purpose  : One framing channel. Tracks sop/eop framing, enforces a maximum
//            packet length, gates the port enable at packet boundaries and
//            keeps a sticky error cause plus a saturating error counter.
// Revision : 1.0 - initial multi-port release
// ============================================================================
module control_port_fsm
  import control_pkg::*;
#(
  parameter int MAX_BEATS = 64,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_port_enable,
  input  logic                 val,
  input  logic                 sop,
  input  logic                 eop,
  input  logic                 err_clr,
  output logic                 enable,
  output logic                 error,
  output logic [1:0]           err_code,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int                    c_CNT_W     = beat_cnt_width(MAX_BEATS);
  localparam bit                    c_LEN_CHECK = (MAX_BEATS != 0);
  // With the check disabled the compare value is irrelevant; 0 keeps it legal
  localparam logic [c_CNT_W-1:0]    c_LAST_BEAT = c_CNT_W'((MAX_BEATS == 0) ? 0 : MAX_BEATS - 1);
  localparam logic [c_CNT_W-1:0]    c_CNT_ONE   = c_CNT_W'(1);
  localparam logic [ERR_CNT_W-1:0]  c_ERR_MAX   = '1;
  localparam logic [ERR_CNT_W-1:0]  c_ERR_ONE   = ERR_CNT_W'(1);

  state_t                r_state;
  state_t                w_next_state;
  logic [c_CNT_W-1:0]    r_beat_cnt;
  logic [c_CNT_W-1:0]    w_next_cnt;
  logic                  w_event;
  err_code_t             w_cause;
  logic                  r_enable;
  logic                  r_error;
  err_code_t             r_err_code;
  err_code_t             w_next_code;
  logic [ERR_CNT_W-1:0]  r_err_cnt;
  logic [ERR_CNT_W-1:0]  w_next_err_cnt;
  logic [ERR_CNT_W-1:0]  w_err_base;
  logic                  w_s;
  logic                  w_e;

  assign w_s = val & sop;
  assign w_e = val & eop;

  // Next-state decode: framing rules, length check and error event detection
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_beat_cnt;
    w_event      = 1'b0;
    w_cause      = ERR_NONE;
    case (r_state)
      ST_RESET: begin
        w_next_state = ST_IDLE;
        w_next_cnt   = '0;
      end
      ST_IDLE, ST_ERROR: begin
        if (w_e && !w_s) begin
          w_next_state = ST_ERROR;
          w_next_cnt   = '0;
          w_event      = 1'b1;
          w_cause      = ERR_EOP_NO_SOP;
        end else if (w_s && !w_e) begin
          w_next_state = ST_WAIT_EOP;
          w_next_cnt   = c_CNT_ONE;
        end else begin
          // Single-beat packets and empty cycles both land in IDLE
          w_next_state = ST_IDLE;
          w_next_cnt   = '0;
        end
      end
      ST_WAIT_EOP: begin
        if (val) begin
          if (w_s) begin
            w_next_state = ST_ERROR;
            w_next_cnt   = '0;
            w_event      = 1'b1;
            w_cause      = ERR_SOP_IN_PKT;
          end else if (w_e) begin
            // EOP outranks the length check, so EOP on beat MAX_BEATS is legal
            w_next_state = ST_IDLE;
            w_next_cnt   = '0;
          end else if (c_LEN_CHECK && (r_beat_cnt == c_LAST_BEAT)) begin
            w_next_state = ST_ERROR;
            w_next_cnt   = '0;
            w_event      = 1'b1;
            w_cause      = ERR_TOO_LONG;
          end else begin
            w_next_cnt   = r_beat_cnt + c_CNT_ONE;
          end
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_cnt   = '0;
      end
    endcase
  end

  // Error bookkeeping: clear is applied first, then any event on top of it
  always_comb begin
    w_err_base     = err_clr ? '0 : r_err_cnt;
    w_next_code    = err_clr ? ERR_NONE : r_err_code;
    w_next_err_cnt = w_err_base;
    if (w_event) begin
      w_next_code    = w_cause;
      w_next_err_cnt = (w_err_base == c_ERR_MAX) ? w_err_base : w_err_base + c_ERR_ONE;
    end
  end

  // State, beat counter and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_RESET;
      r_beat_cnt <= '0;
      r_enable   <= 1'b0;
      r_error    <= 1'b0;
      r_err_code <= ERR_NONE;
      r_err_cnt  <= '0;
    end else begin
      r_state    <= w_next_state;
      r_beat_cnt <= w_next_cnt;
      r_error    <= (w_next_state == ST_ERROR);
      r_err_code <= w_next_code;
      r_err_cnt  <= w_next_err_cnt;
      // Enable only follows cfg at packet boundaries
      if (w_next_state == ST_IDLE || w_next_state == ST_ERROR) begin
        r_enable <= cfg_port_enable;
      end
    end
  end

  assign enable   = r_enable;
  assign error    = r_error;
  assign err_code = r_err_code;
  assign err_cnt  = r_err_cnt;

endmodule
`default_nettype wire

// File: rtl/multi_port_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : multi_port_control_fsm
// Purpose  : NUM_PORTS independent packet framing channels, each with length
//            check, boundary-gated enable and sticky error reporting. Per-port
//            outputs are packed into flat vectors for the CSR block.
// Revision : 1.0 - initial multi-port release
// ============================================================================
module multi_port_control_fsm
  import control_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int MAX_BEATS = 64,
  parameter int ERR_CNT_W = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_PORTS-1:0]           cfg_port_enable,
  input  logic [NUM_PORTS-1:0]           val,
  input  logic [NUM_PORTS-1:0]           sop,
  input  logic [NUM_PORTS-1:0]           eop,
  input  logic [NUM_PORTS-1:0]           err_clr,
  output logic [NUM_PORTS-1:0]           enable,
  output logic [NUM_PORTS-1:0]           error,
  output logic [2*NUM_PORTS-1:0]         err_code,
  output logic [ERR_CNT_W*NUM_PORTS-1:0] err_cnt
);

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    control_port_fsm #(
      .MAX_BEATS (MAX_BEATS),
      .ERR_CNT_W (ERR_CNT_W)
    ) u_port (
      .clk             (clk),
      .reset           (reset),
      .cfg_port_enable (cfg_port_enable[p]),
      .val             (val[p]),
      .sop             (sop[p]),
      .eop             (eop[p]),
      .err_clr         (err_clr[p]),
      .enable          (enable[p]),
      .error           (error[p]),
      .err_code        (err_code[p*2 +: 2]),
      .err_cnt         (err_cnt[p*ERR_CNT_W +: ERR_CNT_W])
    );
  end

endmodule
`default_nettype wire

// File: doc/multi_port_control_fsm.md
Name: multi_port_control_fsm

Overview:
- Parametrised, multi-port successor of the per-port packet framing control FSM.
- Each of NUM_PORTS independent channels checks val/sop/eop framing and gates its port enable at packet boundaries.
- Adds two things per port: a maximum-packet-length check and a sticky error cause with a saturating, clearable error counter.
- Sits between the ingress packet interface and the port datapath/CSR block.

Parameters:
- NUM_PORTS, 4, number of independent channels (1..16).
- MAX_BEATS, 64, maximum beats per packet including SOP and EOP beats; 0 disables the length check.
- ERR_CNT_W, 8, width of each per-port saturating error counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- cfg_port_enable  in  NUM_PORTS  per-port enable request, sampled only at packet boundaries.
- val  in  NUM_PORTS  per-port beat valid.
- sop  in  NUM_PORTS  per-port start of packet, qualified by val.
- eop  in  NUM_PORTS  per-port end of packet, qualified by val.
- err_clr  in  NUM_PORTS  per-port pulse that clears err_cnt and err_code.
- enable  out  NUM_PORTS  registered per-port enable.
- error  out  NUM_PORTS  registered; high while the port state is ERROR.
- err_code  out  2*NUM_PORTS  registered last error cause per port: 0 NONE, 1 EOP_NO_SOP, 2 SOP_IN_PKT, 3 TOO_LONG.
- err_cnt  out  ERR_CNT_W*NUM_PORTS  registered saturating error-event count per port; port p occupies bits [p*ERR_CNT_W +: ERR_CNT_W].

Behaviour:
- Qualified beats per port: s = val & sop, e = val & eop. Ports are fully independent.
- Async reset: state = RESET, beat_cnt = 0, enable = 0, error = 0, err_code = 0, err_cnt = 0 for every port.
- Reset asserted mid-packet aborts the packet immediately; nothing is counted.
- All outputs are registered, so an error is visible one cycle after the offending beat.
- RESET: always goes to IDLE on the next clk.
- IDLE:
  - e & !s -> ERROR, cause EOP_NO_SOP.
  - s & !e -> WAIT_EOP, beat_cnt = 1.
  - s & e -> IDLE (single-beat packet).
  - otherwise stay in IDLE.
- WAIT_EOP, only when val=1; evaluated in this priority:
  1. s -> ERROR, cause SOP_IN_PKT.
  2. e -> IDLE.
  3. MAX_BEATS != 0 and beat_cnt == MAX_BEATS-1 -> ERROR, cause TOO_LONG.
  4. otherwise beat_cnt++.
  - An EOP on beat MAX_BEATS is legal.
  - Idle cycles (val=0) hold both the state and beat_cnt.
- ERROR:
  - e & !s -> stay in ERROR, cause EOP_NO_SOP, counted as a new event.
  - s & !e -> WAIT_EOP, beat_cnt = 1.
  - any other input, including no val -> IDLE.
- beat_cnt width is clog2(MAX_BEATS+1), minimum 1. It is cleared on every entry to IDLE or ERROR.
- Error event: any cycle whose next state is ERROR with a cause assigned.
  - On an event, err_code takes the new cause and err_cnt increments, saturating at 2^ERR_CNT_W-1.
- err_clr[p]: err_cnt = 0 and err_code = NONE.
  - If an event occurs in the same cycle, err_clr wins and then the event applies: result err_cnt = 1, err_code = new cause.
  - err_clr does not affect state or enable.
- enable[p]: when the next state is IDLE or ERROR, enable <= cfg_port_enable[p]; otherwise it holds.
  - A cfg change therefore never takes effect mid-packet.
  - The RESET->IDLE step loads cfg on the first clk after reset deasserts.
- error[p] = (state == ERROR), registered.

Decomposition:
- Package control_pkg holds:
  - state typedef (RESET, IDLE, WAIT_EOP, ERROR; 2 bits).
  - err_code typedef (NONE, EOP_NO_SOP, SOP_IN_PKT, TOO_LONG; 2 bits).
  - beat-count width function.
- Sub-module control_port_fsm implements one channel: FSM, beat_cnt, enable, err_code, err_cnt.
- The top generates NUM_PORTS instances and packs the outputs.

Test Plan:
- Reset then cfg_port_enable=4'b0101, idle -> enable = 4'b0101 one cycle after reset deasserts; error = 0, all err_cnt = 0.
- Port 0 sequence sop, 3 data beats, eop, with cfg toggled to 0 mid-packet -> no error; enable[0] stays 1 until the eop cycle, then goes to 0 on the next clk.
- Port 1 eop without sop, followed by 2 more lone eops -> error[1] high for 3 cycles, err_code = EOP_NO_SOP, err_cnt[1] = 3; other ports unaffected.
- MAX_BEATS=4: sop + 3 non-eop beats -> the 4th beat raises TOO_LONG; a second packet of sop + 2 beats + eop (4 beats) -> no error.
- Port 2: sop, then sop again -> SOP_IN_PKT; err_clr[2] pulsed on the same cycle as a new lone-eop event -> err_cnt[2] = 1, err_code = EOP_NO_SOP.
- ERR_CNT_W=2: 5 error events -> err_cnt saturates at 3; async reset asserted mid-packet -> all outputs zero immediately, no clk edge required.
